// File: rtl/spike_decoder_pkg.sv
// Shared types, default widths and the saturating-increment helper
// for the spike train decoder.
package spike_decoder_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_WINDOW = 1'b1
   } dec_state_e;

   localparam int CNT_W_DEF = 8;
   localparam int ISI_W_DEF = 16;
   localparam int WIN_W_DEF = 16;

   // Adds inc to val but never passes max_val; callers size-cast the result.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic        inc,
                                           input logic [31:0] max_val);
      logic [31:0] res;
      if (inc && (val < max_val)) begin
         res = val + 32'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/spike_isi_meter.sv
// Inter-spike interval meter: measures edges between successive onsets
// while enabled, with a saturating timer and registered result pulse.
module spike_isi_meter
   import spike_decoder_pkg::*;
#(
   parameter int ISI_W = ISI_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable_i,
   input  logic             evt_i,
   output logic [ISI_W-1:0] isi_o,
   output logic             isi_valid_o,
   output logic             isi_sat_o
);

   localparam logic [ISI_W-1:0] ISI_MAX = '1;
   localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};

   logic             have_prev_q;
   logic [ISI_W-1:0] isi_t_q;
   logic [ISI_W-1:0] isi_q;
   logic             isi_valid_q;
   logic             isi_sat_q;
   logic [ISI_W-1:0] isi_t_d;

   // Saturating timer increment.
   always_comb begin
      isi_t_d = ISI_W'(sat_inc(32'(isi_t_q), 1'b1, 32'(ISI_MAX)));
   end

   // Timer, previous-onset flag and registered ISI result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         have_prev_q <= 1'b0;
         isi_t_q     <= '0;
         isi_q       <= '0;
         isi_valid_q <= 1'b0;
         isi_sat_q   <= 1'b0;
      end else begin
         isi_valid_q <= 1'b0;
         if (!enable_i) begin
            have_prev_q <= 1'b0;
            isi_t_q     <= '0;
         end else if (evt_i) begin
            if (have_prev_q) begin
               isi_q       <= isi_t_q;
               isi_sat_q   <= (isi_t_q == ISI_MAX);
               isi_valid_q <= 1'b1;
            end
            have_prev_q <= 1'b1;
            isi_t_q     <= ISI_ONE;
         end else if (have_prev_q) begin
            isi_t_q <= isi_t_d;
         end
      end
   end

   assign isi_o       = isi_q;
   assign isi_valid_o = isi_valid_q;
   assign isi_sat_o   = isi_sat_q;

endmodule

// File: rtl/spike_train_decoder.sv
// Decodes a neuron spike level into a per-window onset count (rate code)
// and an inter-spike interval measurement.
module spike_train_decoder
   import spike_decoder_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int ISI_W = ISI_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             spike,
   input  logic [WIN_W-1:0] window_len,
   output logic [CNT_W-1:0] spike_count,
   output logic             count_valid,
   output logic             count_sat,
   output logic [ISI_W-1:0] isi,
   output logic             isi_valid,
   output logic             isi_sat,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   dec_state_e       state_q;
   logic             spike_q;
   logic [WIN_W-1:0] win_cnt_q;
   logic [CNT_W-1:0] acc_q;
   logic             acc_sat_q;
   logic [CNT_W-1:0] spike_count_q;
   logic             count_sat_q;
   logic             count_valid_q;

   logic             evt;
   logic [CNT_W-1:0] acc_d;
   logic             acc_sat_d;
   logic [WIN_W-1:0] win_load;

   // Onset detect, accumulator next value and window reload length.
   always_comb begin
      evt       = spike & ~spike_q;
      acc_d     = CNT_W'(sat_inc(32'(acc_q), evt, 32'(CNT_MAX)));
      acc_sat_d = acc_sat_q | (evt & (acc_q == CNT_MAX));
      if (window_len == '0) begin
         win_load = WIN_ONE;
      end else begin
         win_load = window_len;
      end
   end

   // Window FSM with registered count outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         spike_q       <= 1'b0;
         win_cnt_q     <= '0;
         acc_q         <= '0;
         acc_sat_q     <= 1'b0;
         spike_count_q <= '0;
         count_sat_q   <= 1'b0;
         count_valid_q <= 1'b0;
      end else begin
         spike_q       <= spike;
         count_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  state_q   <= ST_WINDOW;
                  win_cnt_q <= win_load;
                  acc_q     <= '0;
                  acc_sat_q <= 1'b0;
               end
            end
            ST_WINDOW: begin
               if (win_cnt_q == WIN_ONE) begin
                  // The closing edge still contributes its own onset.
                  spike_count_q <= acc_d;
                  count_sat_q   <= acc_sat_d;
                  count_valid_q <= 1'b1;
                  if (enable) begin
                     win_cnt_q <= win_load;
                     acc_q     <= '0;
                     acc_sat_q <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (!enable) begin
                  state_q <= ST_IDLE;
               end else begin
                  acc_q     <= acc_d;
                  acc_sat_q <= acc_sat_d;
                  win_cnt_q <= win_cnt_q - WIN_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   spike_isi_meter #(
      .ISI_W (ISI_W)
   ) u_isi (
      .clk_i       (clock),
      .rst_ni      (reset),
      .enable_i    (enable),
      .evt_i       (evt),
      .isi_o       (isi),
      .isi_valid_o (isi_valid),
      .isi_sat_o   (isi_sat)
   );

   assign spike_count = spike_count_q;
   assign count_valid = count_valid_q;
   assign count_sat   = count_sat_q;
   assign busy        = (state_q == ST_WINDOW);

endmodule

// File: tb/tb_spike_train_decoder.sv
// Bench for spike_train_decoder: directed scenarios then random stimulus,
// checked against an edge-indexed reference model.
module tb_spike_train_decoder;

   localparam int CNT_W = 4;
   localparam int ISI_W = 4;
   localparam int WIN_W = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;
   localparam int IMAX  = (1 << ISI_W) - 1;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic             spike = 1'b0;
   logic [WIN_W-1:0] window_len = '0;
   logic [CNT_W-1:0] spike_count;
   logic             count_valid;
   logic             count_sat;
   logic [ISI_W-1:0] isi;
   logic             isi_valid;
   logic             isi_sat;
   logic             busy;

   always #5 clock = ~clock;

   spike_train_decoder #(
      .CNT_W (CNT_W),
      .ISI_W (ISI_W),
      .WIN_W (WIN_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .spike       (spike),
      .window_len  (window_len),
      .spike_count (spike_count),
      .count_valid (count_valid),
      .count_sat   (count_sat),
      .isi         (isi),
      .isi_valid   (isi_valid),
      .isi_sat     (isi_sat),
      .busy        (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: windows tracked by start edge and length, ISI by
   // the edge number of the last onset.
   int edge_n = 0;
   bit m_spk, m_inwin, m_have;
   int m_start, m_len, m_cnt, m_last;
   bit exp_cv, exp_iv, exp_csat, exp_isat, exp_busy;
   int exp_count, exp_isi;

   task automatic model_reset();
      m_spk = 1'b0; m_inwin = 1'b0; m_have = 1'b0; m_cnt = 0;
      exp_cv = 1'b0; exp_iv = 1'b0; exp_csat = 1'b0; exp_isat = 1'b0;
      exp_busy = 1'b0; exp_count = 0; exp_isi = 0;
   endtask

   task automatic model_edge(input bit sp, input bit en, input int wl);
      bit evt;
      int d;
      evt = sp && !m_spk;
      m_spk = sp;
      edge_n++;
      exp_cv = 1'b0;
      exp_iv = 1'b0;
      if (!m_inwin) begin
         if (en) begin
            m_inwin = 1'b1; m_start = edge_n; m_cnt = 0;
            m_len = (wl == 0) ? 1 : wl;
         end
      end else begin
         if (evt) m_cnt++;
         if (edge_n == m_start + m_len) begin
            exp_cv = 1'b1;
            exp_count = (m_cnt > CMAX) ? CMAX : m_cnt;
            exp_csat = (m_cnt > CMAX);
            if (en) begin
               m_start = edge_n; m_cnt = 0;
               m_len = (wl == 0) ? 1 : wl;
            end else begin
               m_inwin = 1'b0;
            end
         end else if (!en) begin
            m_inwin = 1'b0;
         end
      end
      exp_busy = m_inwin;
      if (!en) begin
         m_have = 1'b0;
      end else if (evt) begin
         if (m_have) begin
            d = edge_n - m_last;
            exp_iv = 1'b1;
            exp_isi = (d > IMAX) ? IMAX : d;
            exp_isat = (d >= IMAX);
         end
         m_have = 1'b1;
         m_last = edge_n;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("count_valid", 32'(count_valid), 32'(exp_cv));
      chk("spike_count", 32'(spike_count), 32'(exp_count));
      chk("count_sat",   32'(count_sat),   32'(exp_csat));
      chk("isi_valid",   32'(isi_valid),   32'(exp_iv));
      chk("isi",         32'(isi),         32'(exp_isi));
      chk("isi_sat",     32'(isi_sat),     32'(exp_isat));
      chk("busy",        32'(busy),        32'(exp_busy));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
   task automatic step(input bit sp, input bit en, input int wl);
      spike = sp;
      enable = en;
      window_len = WIN_W'(wl);
      @(posedge clock);
      model_edge(sp, en, wl);
      #1;
      check_all();
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (hold) @(posedge clock);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   bit sp_r;

   initial begin
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;

      // Basic window: three single-cycle spikes in a 10-edge window.
      step(1'b0, 1'b1, 10);
      for (int i = 0; i < 10; i++) step((i == 1) || (i == 4) || (i == 7), 1'b1, 10);
      chk("basic_valid", 32'(count_valid), 32'd1);
      chk("basic_count", 32'(spike_count), 32'd3);
      chk("basic_sat",   32'(count_sat),   32'd0);
      step(1'b0, 1'b1, 10);
      chk("basic_nogap", 32'(busy), 32'd1);

      // ISI: 4-cycle pulse then an onset 7 edges after the first.
      step(1'b0, 1'b0, 10);
      step(1'b0, 1'b1, 10);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 10);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10);
      step(1'b1, 1'b1, 10);
      chk("isi_valid7", 32'(isi_valid), 32'd1);
      chk("isi_val7",   32'(isi),       32'd7);

      // Count saturation: 20 onsets in a 40-edge window.
      step(1'b0, 1'b0, 40);
      step(1'b0, 1'b1, 40);
      for (int i = 0; i < 40; i++) step((i % 2) == 0, 1'b1, 40);
      chk("sat_valid", 32'(count_valid), 32'd1);
      chk("sat_count", 32'(spike_count), 32'd15);
      chk("sat_flag",  32'(count_sat),   32'd1);

      // Abort at cycle 5, then a full fresh window.
      step(1'b0, 1'b0, 10);
      step(1'b0, 1'b1, 10);
      for (int i = 0; i < 4; i++) step(i == 1, 1'b1, 10);
      step(1'b0, 1'b0, 10);
      chk("abort_busy",  32'(busy),        32'd0);
      chk("abort_valid", 32'(count_valid), 32'd0);
      step(1'b0, 1'b1, 10);
      for (int i = 0; i < 10; i++) step(i == 3, 1'b1, 10);
      chk("reenter_valid", 32'(count_valid), 32'd1);
      chk("reenter_count", 32'(spike_count), 32'd1);

      // Zero window length closes on every edge; reset then kills the pulse.
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      for (int i = 0; i < 5; i++) begin
         step(i == 2, 1'b1, 0);
         chk("wl0_valid", 32'(count_valid), 32'd1);
      end
      do_reset(1);

      // ISI saturation: onsets 20 edges apart.
      step(1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 0);
      for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 0);
      step(1'b1, 1'b1, 0);
      chk("isisat_valid", 32'(isi_valid), 32'd1);
      chk("isisat_val",   32'(isi),       32'd15);
      chk("isisat_flag",  32'(isi_sat),   32'd1);

      // Reset mid-window with the spike held high.
      step(1'b0, 1'b0, 8);
      step(1'b0, 1'b1, 8);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8);
      step(1'b1, 1'b1, 8);
      do_reset(2);
      step(1'b1, 1'b0, 8);
      step(1'b1, 1'b1, 8);
      chk("post_reset_busy", 32'(busy), 32'd1);

      // Random stimulus against the model.
      sp_r = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset(2);
         end else begin
            if ($urandom_range(0, 2) == 0) sp_r = ~sp_r;
            step(sp_r, $urandom_range(0, 24) != 0, int'($urandom_range(0, 9)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spike_train_decoder.md
# spike_train_decoder

Receive-side companion to the neuron model: consumes the `spike` output of the Hodgkin-Huxley neuron and decodes it back into numbers. It detects spike onsets and counts them over a programmable window to give a rate code. In parallel it measures the inter-spike interval (ISI) in clock cycles. Results go to the readout and debug logic as single-cycle valid pulses.

## Interface
- `CNT_W`, 8: width of the per-window spike count.
- `ISI_W`, 16: width of the ISI measurement.
- `WIN_W`, 16: width of the window length.

- `clock`  input  1  single system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset (low = reset asserted).
- `enable`  input  1  level; high runs the decoder, low returns it to idle.
- `spike`  input  1  level from the neuron; may stay high for many cycles.
- `window_len`  input  WIN_W  window length in cycles; sampled only at window start.
- `spike_count`  output  CNT_W  onsets counted in the last completed window.
- `count_valid`  output  1  one-cycle pulse when `spike_count` updates.
- `count_sat`  output  1  count in the last window saturated; qualified by `count_valid`.
- `isi`  output  ISI_W  cycles between the last two onsets.
- `isi_valid`  output  1  one-cycle pulse when `isi` updates.
- `isi_sat`  output  1  last ISI saturated; qualified by `isi_valid`.
- `busy`  output  1  high while in WINDOW.

## Operation
- **Onset detect.** Register `spike_q`.
  - An event occurs at edge k when `spike` is sampled 1 at k and `spike_q` is 0.
  - `spike_q` resets to 0, so a spike already high out of reset counts as an event.
- **Window FSM, two states: IDLE and WINDOW.**
  - IDLE → WINDOW at an edge that samples `enable`=1.
  - On that transition: load `win_cnt` ← `window_len` (0 is treated as 1) and clear `acc` ← 0.
  - An event at the entry edge is not counted.
- **In WINDOW, at each edge:**
  - `acc` ← `acc` + event, saturating at 2^CNT_W−1.
  - `win_cnt` decrements.
- **Window close.** At the edge where `win_cnt`==1:
  - `spike_count` ← `acc` + event (saturated); `count_sat` ← saturation seen; `count_valid` ← 1.
  - If `enable`=1: reload `win_cnt` from the current `window_len` and clear `acc`. Back-to-back windows have no gap cycle.
  - Otherwise go to IDLE.
- **Abort.** `enable`=0 sampled mid-window (before the close edge):
  - Go to IDLE at that edge.
  - Discard `acc`; no `count_valid`.
- **ISI meter.** Runs whenever `enable`=1, independent of the window FSM.
  - Flag `have_prev` and timer `isi_t` (saturates at 2^ISI_W−1).
  - Event with `have_prev`=0: set `have_prev`, `isi_t` ← 1, no output.
  - Event with `have_prev`=1: `isi` ← `isi_t`, `isi_sat` ← (`isi_t` saturated), `isi_valid` ← 1, `isi_t` ← 1.
  - No event: `isi_t` increments (saturating) while `have_prev`=1.
  - `enable`=0 clears `have_prev` and `isi_t`.
  - Result: onsets at edges 10 and 15 give `isi`=5.
- **Reset values.** Every output and internal register is 0; state is IDLE.

## Timing
- All outputs are registered.
- `isi_valid` is high in the cycle after the edge that sampled the second onset.
- `count_valid` is high in the cycle after the window's last edge. Windows of length N start every N edges while enabled.
- A window close and an ISI event on the same edge both fire; the outputs are independent.
- `spike_count`, `count_sat`, `isi` and `isi_sat` hold their values between valid pulses.
- `window_len` changes mid-window take effect at the next reload only.
- Reset asserted mid-operation clears everything immediately, including any pending valid pulse. After release, the first enabled edge starts a fresh window.

## Structure
- Package `spike_decoder_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_WINDOW`);
  - default width constants;
  - a saturating-increment function shared by the counters.
- Sub-module `spike_isi_meter` contains the ISI timer, `have_prev` and the `isi*` outputs.
- The top level holds the onset detect, which feeds `spike_isi_meter` a one-cycle event, plus the window FSM.

## Test plan
1. **Basic window.** `window_len`=10, `enable`=1. Three 1-cycle spikes inside the window → `count_valid` pulse with `spike_count`=3, `count_sat`=0. The next window starts with no gap.
2. **ISI.** Spike held high for 4 cycles starting at edge 20, next onset at edge 27 → exactly one `isi_valid`, with `isi`=7. The long pulse counts as one onset.
3. **Count saturation.** `CNT_W`=4, `window_len`=40, spike toggling every other cycle (20 onsets) → `spike_count`=15, `count_sat`=1.
4. **Abort.** `enable` drops at cycle 5 of a 10-cycle window → no `count_valid`, `busy` falls. Re-enabling starts a full new window.
5. **Edge cases.** `window_len`=0 → `count_valid` every cycle. Reset asserted mid-window with a spike pending → all outputs 0, no valid pulse after release until a new window or onset pair completes.
6. **ISI saturation.** `ISI_W`=4, onsets 20 cycles apart → `isi`=15, `isi_sat`=1.
